// File: rtl/dsm_regs_pkg.sv
// Shared register-map offsets, CTRL bit positions and AXI response codes
// for the DSM control register block.
package dsm_regs_pkg;

   localparam int unsigned REG_ID     = 0;
   localparam int unsigned REG_CTRL   = 1;
   localparam int unsigned REG_STEP   = 2;
   localparam int unsigned REG_STATUS = 3;

   localparam int unsigned CTRL_NCO_EN    = 0;
   localparam int unsigned CTRL_DITHER_EN = 1;
   localparam int unsigned CTRL_COMMIT    = 8;

   localparam int unsigned STATUS_LOCKED = 0;
   localparam int unsigned STATUS_DIRTY  = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_wr_hold.sv
// AXI4-Lite write-side capture: holds AW and W independently, pairs them into
// one write strobe and owns the B-channel valid.
module axil_wr_hold #(
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  aclk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [31:0]           wdata,
   input  logic [3:0]            wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic                  bvalid,
   input  logic                  bready,
   output logic                  wr_en_c,
   output logic [ADDR_WIDTH-1:0] wr_addr_c,
   output logic [31:0]           wr_data_c,
   output logic [3:0]            wr_strb_c
);

   logic                  aw_held_q, aw_held_n;
   logic                  w_held_q, w_held_n;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           data_q;
   logic [3:0]            strb_q;
   logic                  bvalid_n;
   logic                  aw_hs, w_hs;

   // Pairing and next-state; a live handshake bypasses the holding register.
   always_comb begin
      aw_hs     = awvalid && awready;
      w_hs      = wvalid && wready;
      wr_en_c   = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid;
      wr_addr_c = aw_held_q ? addr_q : awaddr;
      wr_data_c = w_held_q ? data_q : wdata;
      wr_strb_c = w_held_q ? strb_q : wstrb;

      aw_held_n = aw_held_q;
      w_held_n  = w_held_q;
      bvalid_n  = bvalid;
      if (aw_hs)            aw_held_n = 1'b1;
      if (w_hs)             w_held_n  = 1'b1;
      if (bvalid && bready) bvalid_n  = 1'b0;
      if (wr_en_c) begin
         aw_held_n = 1'b0;
         w_held_n  = 1'b0;
         bvalid_n  = 1'b1;
      end
   end

   // Ready is registered from the next-state so it matches !held && !bvalid.
   always_ff @(posedge aclk) begin
      if (rst) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         bvalid    <= 1'b0;
         awready   <= 1'b0;
         wready    <= 1'b0;
      end else begin
         aw_held_q <= aw_held_n;
         w_held_q  <= w_held_n;
         if (aw_hs) addr_q <= awaddr;
         if (w_hs) begin
            data_q <= wdata;
            strb_q <= wstrb;
         end
         bvalid  <= bvalid_n;
         awready <= !aw_held_n && !bvalid_n;
         wready  <= !w_held_n && !bvalid_n;
      end
   end

endmodule

// File: rtl/axil_dsm_regs.sv
// AXI4-Lite register file for the DSM datapath: ID, CTRL, double-buffered
// NCO step with commit, and read-only status.
module axil_dsm_regs
   import dsm_regs_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter logic [31:0] STEP_RESET = 32'd0,
   parameter logic [31:0] ID_VALUE   = 32'h4D41_5348
) (
   input  logic                  aclk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [31:0]           s_axil_wdata,
   input  logic [3:0]            s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [31:0]           s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   input  logic                  mmcm_locked,
   output logic [ACC_WIDTH-1:0]  nco_step,
   output logic                  nco_step_enable,
   output logic                  dither_enable,
   output logic                  step_update
);

   localparam int unsigned IDX_W          = ADDR_WIDTH - 2;
   localparam int unsigned STEP_BYTES     = (ACC_WIDTH + 7) / 8;
   localparam logic [3:0]  STEP_STRB_MASK = 4'((1 << STEP_BYTES) - 1);

   logic                  wr_en_c;
   logic [ADDR_WIDTH-1:0] wr_addr_c;
   logic [31:0]           wr_data_c;
   logic [3:0]            wr_strb_c;

   logic [ACC_WIDTH-1:0]  shadow_q;
   logic                  dirty_q;
   logic [IDX_W-1:0]      wr_idx_c, rd_idx_c;
   logic                  wr_ctrl_c, wr_step_c, commit_c;
   logic [31:0]           step_word_c;
   logic [31:0]           rd_data_c;
   logic [1:0]            rd_resp_c;
   logic                  ar_hs_c, rvalid_n_c;
   logic                  unused_addr_bits;

   axil_wr_hold #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_wr_hold (
      .aclk      (aclk),
      .rst       (rst),
      .awaddr    (s_axil_awaddr),
      .awvalid   (s_axil_awvalid),
      .awready   (s_axil_awready),
      .wdata     (s_axil_wdata),
      .wstrb     (s_axil_wstrb),
      .wvalid    (s_axil_wvalid),
      .wready    (s_axil_wready),
      .bvalid    (s_axil_bvalid),
      .bready    (s_axil_bready),
      .wr_en_c   (wr_en_c),
      .wr_addr_c (wr_addr_c),
      .wr_data_c (wr_data_c),
      .wr_strb_c (wr_strb_c)
   );

   // Byte-lane offsets are not part of the decode.
   assign unused_addr_bits = ^{wr_addr_c[1:0], s_axil_araddr[1:0]};

   // Write decode and byte-merge of the shadow step.
   always_comb begin
      wr_idx_c    = wr_addr_c[ADDR_WIDTH-1:2];
      wr_ctrl_c   = wr_en_c && (wr_idx_c == IDX_W'(REG_CTRL));
      wr_step_c   = wr_en_c && (wr_idx_c == IDX_W'(REG_STEP));
      commit_c    = wr_ctrl_c && wr_strb_c[1] && wr_data_c[CTRL_COMMIT];
      step_word_c = 32'(shadow_q);
      for (int b = 0; b < 4; b++) begin
         if (wr_strb_c[b]) step_word_c[8*b +: 8] = wr_data_c[8*b +: 8];
      end
   end

   // Read mux over current (pre-write) register values.
   always_comb begin
      rd_idx_c   = s_axil_araddr[ADDR_WIDTH-1:2];
      rd_data_c  = '0;
      rd_resp_c  = RESP_OKAY;
      ar_hs_c    = s_axil_arvalid && s_axil_arready;
      rvalid_n_c = s_axil_rvalid;
      if (s_axil_rvalid && s_axil_rready) rvalid_n_c = 1'b0;
      if (ar_hs_c)                        rvalid_n_c = 1'b1;
      case (rd_idx_c)
         IDX_W'(REG_ID):   rd_data_c = ID_VALUE;
         IDX_W'(REG_CTRL): begin
            rd_data_c[CTRL_NCO_EN]    = nco_step_enable;
            rd_data_c[CTRL_DITHER_EN] = dither_enable;
         end
         IDX_W'(REG_STEP): rd_data_c = 32'(shadow_q);
         IDX_W'(REG_STATUS): begin
            rd_data_c[STATUS_LOCKED] = mmcm_locked;
            rd_data_c[STATUS_DIRTY]  = dirty_q;
         end
         default: rd_resp_c = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         shadow_q        <= ACC_WIDTH'(STEP_RESET);
         nco_step        <= ACC_WIDTH'(STEP_RESET);
         nco_step_enable <= 1'b1;
         dither_enable   <= 1'b0;
         step_update     <= 1'b0;
         dirty_q         <= 1'b0;
         s_axil_bresp    <= RESP_OKAY;
         s_axil_arready  <= 1'b0;
         s_axil_rvalid   <= 1'b0;
         s_axil_rdata    <= '0;
         s_axil_rresp    <= RESP_OKAY;
      end else begin
         step_update <= commit_c;
         if (wr_en_c) s_axil_bresp <= (wr_ctrl_c || wr_step_c) ? RESP_OKAY : RESP_SLVERR;
         if (wr_ctrl_c && wr_strb_c[0]) begin
            nco_step_enable <= wr_data_c[CTRL_NCO_EN];
            dither_enable   <= wr_data_c[CTRL_DITHER_EN];
         end
         if (wr_step_c) shadow_q <= ACC_WIDTH'(step_word_c);
         if (commit_c) begin
            nco_step <= shadow_q;
            dirty_q  <= 1'b0;
         end else if (wr_step_c && |(wr_strb_c & STEP_STRB_MASK)) begin
            dirty_q <= 1'b1;
         end
         if (ar_hs_c) begin
            s_axil_rdata <= rd_data_c;
            s_axil_rresp <= rd_resp_c;
         end
         s_axil_rvalid  <= rvalid_n_c;
         s_axil_arready <= !rvalid_n_c;
      end
   end

endmodule

// File: tb/tb_axil_dsm_regs.sv
// Self-checking bench for axil_dsm_regs: directed scenarios plus randomized
// register traffic checked against a behavioural register-map model.
module tb_axil_dsm_regs;

   logic        aclk = 1'b0;
   logic        rst  = 1'b1;
   logic [4:0]  awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [4:0]  araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        mmcm_locked = 1'b0;
   logic [31:0] nco_step;
   logic        nco_step_enable;
   logic        dither_enable;
   logic        step_update;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the register map
   logic [31:0] m_shadow, m_step;
   logic        m_en, m_dith, m_dirty;

   always #5 aclk = ~aclk;

   axil_dsm_regs dut (
      .aclk            (aclk),
      .rst             (rst),
      .s_axil_awaddr   (awaddr),
      .s_axil_awvalid  (awvalid),
      .s_axil_awready  (awready),
      .s_axil_wdata    (wdata),
      .s_axil_wstrb    (wstrb),
      .s_axil_wvalid   (wvalid),
      .s_axil_wready   (wready),
      .s_axil_bresp    (bresp),
      .s_axil_bvalid   (bvalid),
      .s_axil_bready   (bready),
      .s_axil_araddr   (araddr),
      .s_axil_arvalid  (arvalid),
      .s_axil_arready  (arready),
      .s_axil_rdata    (rdata),
      .s_axil_rresp    (rresp),
      .s_axil_rvalid   (rvalid),
      .s_axil_rready   (rready),
      .mmcm_locked     (mmcm_locked),
      .nco_step        (nco_step),
      .nco_step_enable (nco_step_enable),
      .dither_enable   (dither_enable),
      .step_update     (step_update)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_shadow = 32'h0; m_step = 32'h0; m_en = 1'b1; m_dith = 1'b0; m_dirty = 1'b0;
   endtask

   task automatic m_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic commit);
      int word;
      word = int'(a) / 4;
      commit = 1'b0;
      resp = 2'b10;
      if (word == 1) begin
         resp = 2'b00;
         if (s[0]) begin m_en = d[0]; m_dith = d[1]; end
         if (s[1] && d[8]) begin commit = 1'b1; m_step = m_shadow; m_dirty = 1'b0; end
      end else if (word == 2) begin
         resp = 2'b00;
         for (int b = 0; b < 4; b++)
            if (s[b]) m_shadow[8*b +: 8] = d[8*b +: 8];
         if (s != 4'b0) m_dirty = 1'b1;
      end
   endtask

   task automatic m_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      int word;
      word = int'(a) / 4;
      d = 32'h0;
      resp = 2'b00;
      case (word)
         0: d = 32'h4D41_5348;
         1: d = {30'h0, m_dith, m_en};
         2: d = m_shadow;
         3: d = {30'h0, m_dirty, mmcm_locked};
         default: resp = 2'b10;
      endcase
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic upd0, output logic upd1,
                            output logic ok);
      logic aw_d, w_d, hs_aw, hs_w;
      int n;
      aw_d = 1'b0; w_d = 1'b0; n = 0;
      ok = 1'b0; resp = 2'b11; upd0 = 1'b0; upd1 = 1'b0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      while (!(aw_d && w_d) && n < 20) begin
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         @(posedge aclk); #1; n++;
         if (hs_aw) begin awvalid = 1'b0; aw_d = 1'b1; end
         if (hs_w)  begin wvalid  = 1'b0; w_d  = 1'b1; end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
      if (bvalid) begin
         ok = 1'b1; resp = bresp; upd0 = step_update;
         @(posedge aclk); #1;
         upd1 = step_update;
      end
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r,
                           output logic ok);
      logic hs;
      int n;
      hs = 1'b0; n = 0; ok = 1'b0; d = 32'h0; r = 2'b11;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      while (!hs && n < 20) begin
         hs = arvalid && arready;
         @(posedge aclk); #1; n++;
      end
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
      if (rvalid) begin
         ok = 1'b1; d = rdata; r = rresp;
         @(posedge aclk); #1;
      end
      rready = 1'b0;
   endtask

   // Write with model prediction and full output comparison
   task automatic do_write(input string tag, input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      logic [1:0] resp, eresp;
      logic u0, u1, ok, ecommit;
      m_write(a, d, s, eresp, ecommit);
      axi_write(a, d, s, resp, u0, u1, ok);
      check({tag, "_bdone"}, 32'(ok), 32'd1);
      check({tag, "_bresp"}, 32'(resp), 32'(eresp));
      check({tag, "_upd"}, {30'h0, u1, u0}, {31'h0, ecommit});
      check({tag, "_step"}, nco_step, m_step);
      check({tag, "_ctrl"}, {30'h0, dither_enable, nco_step_enable}, {30'h0, m_dith, m_en});
   endtask

   task automatic do_read(input string tag, input logic [4:0] a, input logic [31:0] ed,
                          input logic [1:0] er);
      logic [31:0] d;
      logic [1:0] r;
      logic ok;
      axi_read(a, d, r, ok);
      check({tag, "_rdone"}, 32'(ok), 32'd1);
      check({tag, "_rdata"}, d, ed);
      check({tag, "_rresp"}, 32'(r), 32'(er));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ed, rd_d;
      logic [1:0]  er, rd_r, wr_r;
      logic [4:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        ok, hs_aw, hs_w, aw_d, w_d, ar_d, hs_ar, u0, u1;
      int          n;

      m_reset();
      repeat (3) @(posedge aclk);
      #1;
      check("rst_ready", {29'h0, awready, wready, arready}, 32'h0);
      check("rst_valid", {30'h0, bvalid, rvalid}, 32'h0);
      check("rst_resp", {28'h0, bresp, rresp}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_step", nco_step, 32'h0);
      check("rst_ctrl", {29'h0, step_update, dither_enable, nco_step_enable}, 32'h1);
      rst = 1'b0;
      mmcm_locked = 1'b1;

      do_read("id", 5'h00, 32'h4D41_5348, 2'b00);
      do_read("ctrl0", 5'h04, 32'h1, 2'b00);

      // Shadow write leaves the active step alone until commit
      do_write("step_wr", 5'h08, 32'h0012_3456, 4'hF);
      do_read("status_dirty", 5'h0C, 32'h3, 2'b00);
      check("step_held", nco_step, 32'h0);
      do_write("commit", 5'h04, 32'h0000_0103, 4'hF);
      check("commit_step", nco_step, 32'h0012_3456);
      check("commit_dither", 32'(dither_enable), 32'd1);
      do_read("status_clean", 5'h0C, 32'h1, 2'b00);

      // W arrives three cycles ahead of AW; B held off for five cycles
      awaddr = 5'h04; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
      check("early_wready", 32'(wready), 32'd1);
      @(posedge aclk); #1;
      wvalid = 1'b0;
      check("w_held_wready", 32'(wready), 32'd0);
      check("w_held_nob", 32'(bvalid), 32'd0);
      repeat (2) begin @(posedge aclk); #1; end
      awvalid = 1'b1;
      check("late_awready", 32'(awready), 32'd1);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      m_write(5'h04, 32'h1, 4'hF, er, u0);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bhold%0d_bvalid", k), 32'(bvalid), 32'd1);
         check($sformatf("bhold%0d_bresp", k), 32'(bresp), 32'(er));
         check($sformatf("bhold%0d_awready", k), 32'(awready), 32'd0);
         @(posedge aclk); #1;
      end
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
      check("bhold_release", 32'(bvalid), 32'd0);
      check("bhold_ctrl", {30'h0, dither_enable, nco_step_enable}, 32'h1);

      // Read-only and unmapped targets
      do_write("wr_id", 5'h00, 32'hFFFF_FFFF, 4'hF);
      do_write("wr_unmapped", 5'h14, 32'hFFFF_FFFF, 4'hF);
      do_read("rd_unmapped", 5'h18, 32'h0, 2'b10);
      do_read("ctrl_after_ro", 5'h04, 32'h1, 2'b00);

      // Single-byte strobe into a cleared shadow
      do_write("step_clr", 5'h08, 32'h0, 4'hF);
      do_write("step_strb", 5'h08, 32'hAAAA_BBBB, 4'b0010);
      do_read("step_strb_rd", 5'h08, 32'h0000_BB00, 2'b00);
      do_write("strb_zero", 5'h08, 32'h1234_5678, 4'b0000);
      do_read("strb_zero_rd", 5'h08, 32'h0000_BB00, 2'b00);

      // Randomized traffic against the model
      for (int i = 0; i < 60; i++) begin
         n = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 7));
         a = {3'(n), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write($sformatf("rnd%0d_w%02h", i, a), a, d, s);
         end else begin
            mmcm_locked = 1'($urandom_range(0, 1));
            m_read(a, ed, er);
            do_read($sformatf("rnd%0d_r%02h", i, a), a, ed, er);
         end
      end

      // Load a nonzero active step and dither before the mid-transaction reset
      do_write("pre_step", 5'h08, 32'hCAFE_0001, 4'hF);
      do_write("pre_commit", 5'h04, 32'h0000_0102, 4'hF);
      check("pre_rst_step", nco_step, 32'hCAFE_0001);

      awaddr = 5'h08; wdata = $urandom; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 5'h00; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
      aw_d = 1'b0; w_d = 1'b0; ar_d = 1'b0; n = 0;
      while (!(bvalid && rvalid) && n < 20) begin
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         hs_ar = arvalid && arready;
         @(posedge aclk); #1; n++;
         if (hs_aw) begin awvalid = 1'b0; aw_d = 1'b1; end
         if (hs_w)  begin wvalid  = 1'b0; w_d  = 1'b1; end
         if (hs_ar) begin arvalid = 1'b0; ar_d = 1'b1; end
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("pre_rst_valids", {30'h0, bvalid, rvalid}, 32'h3);
      rst = 1'b1;
      @(posedge aclk); #1;
      rst = 1'b0;
      m_reset();
      check("midrst_valids", {30'h0, bvalid, rvalid}, 32'h0);
      check("midrst_step", nco_step, 32'h0);
      check("midrst_ctrl", {30'h0, dither_enable, nco_step_enable}, 32'h1);
      check("midrst_upd", 32'(step_update), 32'd0);
      do_read("postrst_step", 5'h08, 32'h0, 2'b00);
      mmcm_locked = 1'b0;
      do_read("postrst_status", 5'h0C, 32'h0, 2'b00);

      // Throughput/latency sanity after reset: back-to-back write still responds
      axi_write(5'h04, 32'h3, 4'h1, wr_r, u0, u1, ok);
      check("post_wr_done", 32'(ok), 32'd1);
      check("post_wr_resp", 32'(wr_r), 32'd0);
      axi_read(5'h04, rd_d, rd_r, ok);
      check("post_rd", rd_d, 32'h3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
